// File: rtl/rpc2_ctrl_arb_pkg.sv
// rpc2_ctrl_arb_pkg: shared FSM state type, arbitration mode encodings and width helpers
package rpc2_ctrl_arb_pkg;
    typedef enum logic [1:0] {IDLE, CALC, ISSUE, WAIT} arb_state_e;
    localparam logic ARB_RR = 1'b0;
    localparam logic ARB_FIXED = 1'b1;
    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_MAX_BEATS = 64;
    localparam int DEF_PORT_W = $clog2(DEF_NUM_PORTS);
    localparam int DEF_BEATS_W = $clog2(DEF_MAX_BEATS) + 1;
    function automatic int beats_w(input int max_beats);
        return $clog2(max_beats) + 1;
    endfunction
endpackage

// File: rtl/rpc2_ctrl_port_arbiter_if.sv
// rpc2_ctrl_port_arbiter_if: requester and chunk-command signals between requesters, arbiter and sequencer
interface rpc2_ctrl_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W = 8,
    parameter int ID_W = 4,
    parameter int MAX_BEATS = 64
);
    import rpc2_ctrl_arb_pkg::*;
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int BEATS_W = beats_w(MAX_BEATS);
    logic [NUM_PORTS-1:0] req_valid;
    logic [NUM_PORTS-1:0] req_ready;
    logic [NUM_PORTS-1:0] req_write;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*LEN_W-1:0] req_len;
    logic [NUM_PORTS*ID_W-1:0] req_id;
    logic cfg_mode;
    logic cmd_valid;
    logic cmd_ready;
    logic cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BEATS_W-1:0] cmd_beats;
    logic cmd_last;
    logic [PORT_W-1:0] cmd_port;
    logic [ID_W-1:0] cmd_id;
    logic done;
    logic busy;
    modport slave (
        input req_valid, req_write, req_addr, req_len, req_id, cfg_mode, cmd_ready, done,
        output req_ready, cmd_valid, cmd_write, cmd_addr, cmd_beats, cmd_last, cmd_port, cmd_id, busy
    );
    modport master (
        output req_valid, req_write, req_addr, req_len, req_id, cfg_mode, cmd_ready, done,
        input req_ready, cmd_valid, cmd_write, cmd_addr, cmd_beats, cmd_last, cmd_port, cmd_id, busy
    );
endinterface

// File: rtl/rpc2_ctrl_arb_pick.sv
// rpc2_ctrl_arb_pick: per-port aging, round-robin pointer and winner selection
module rpc2_ctrl_arb_pick
    import rpc2_ctrl_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int AGE_W = 8,
    parameter int AGE_LIMIT = 200,
    parameter int PORT_W = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 mode_i,
    input  logic [NUM_PORTS-1:0] valid_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PORT_W-1:0]    gnt_idx_o,
    output logic                 gnt_any_o
);
    logic [AGE_W-1:0] age_q [NUM_PORTS];
    logic [AGE_W-1:0] age_d [NUM_PORTS];
    logic [PORT_W-1:0] ptr_q, ptr_d, aged_idx, fix_idx, rr_idx;
    logic aged_hit;

    // Descending scans leave the lowest qualifying index (or smallest RR offset) as the winner
    always_comb begin
        aged_hit = 1'b0;
        aged_idx = '0;
        fix_idx = '0;
        rr_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (valid_i[i] && int'(age_q[i]) >= AGE_LIMIT) begin
                aged_hit = 1'b1;
                aged_idx = PORT_W'(i);
            end
            if (valid_i[i]) fix_idx = PORT_W'(i);
            if (valid_i[(int'(ptr_q) + i) % NUM_PORTS]) rr_idx = PORT_W'((int'(ptr_q) + i) % NUM_PORTS);
        end
        gnt_idx_o = aged_hit ? aged_idx : (mode_i == ARB_FIXED) ? fix_idx : rr_idx;
        gnt_any_o = en_i && (|valid_i);
        gnt_o = gnt_any_o ? (NUM_PORTS'(1) << gnt_idx_o) : '0;
        ptr_d = !gnt_any_o ? ptr_q : (int'(gnt_idx_o) == NUM_PORTS - 1) ? '0 : gnt_idx_o + 1'b1;
        for (int i = 0; i < NUM_PORTS; i++)
            age_d[i] = (!valid_i[i] || gnt_o[i]) ? '0 : (&age_q[i]) ? age_q[i] : age_q[i] + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) age_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            age_q <= age_d;
        end
    end
endmodule

// File: rtl/rpc2_ctrl_port_arbiter.sv
// rpc2_ctrl_port_arbiter: shares the single-outstanding PSRAM sequencer between NUM_PORTS requesters,
// splitting each burst into chunks bounded by tCEM and the page boundary
module rpc2_ctrl_port_arbiter
    import rpc2_ctrl_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W = 8,
    parameter int ID_W = 4,
    parameter int BEAT_BYTES = 2,
    parameter int MAX_BEATS = 64,
    parameter int PAGE_BYTES = 2048,
    parameter int AGE_W = 8,
    parameter int AGE_LIMIT = 200
) (
    input logic clk,
    input logic rst,
    rpc2_ctrl_port_arbiter_if.slave bus
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int BEATS_W = beats_w(MAX_BEATS);
    localparam int BB_LG = $clog2(BEAT_BYTES);
    localparam int PG_LG = $clog2(PAGE_BYTES);
    localparam int RW = LEN_W + 1;

    arb_state_e state_q;
    logic wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RW-1:0] rem_q;
    logic [ID_W-1:0] id_q;
    logic [PORT_W-1:0] port_q;
    logic cmd_valid_q, cmd_write_q, cmd_last_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [BEATS_W-1:0] cmd_beats_q;
    logic [PORT_W-1:0] cmd_port_q;
    logic [ID_W-1:0] cmd_id_q;
    logic [NUM_PORTS-1:0] gnt;
    logic [PORT_W-1:0] gnt_idx;
    logic gnt_any;
    logic [31:0] room, rem_w;
    logic [BEATS_W-1:0] chunk;

    rpc2_ctrl_arb_pick #(
        .NUM_PORTS(NUM_PORTS),
        .AGE_W(AGE_W),
        .AGE_LIMIT(AGE_LIMIT)
    ) u_pick (
        .clk(clk),
        .rst(rst),
        .en_i(state_q == IDLE),
        .mode_i(bus.cfg_mode),
        .valid_i(bus.req_valid),
        .gnt_o(gnt),
        .gnt_idx_o(gnt_idx),
        .gnt_any_o(gnt_any)
    );

    // chunk = min(remaining, MAX_BEATS, beats left before the page boundary)
    always_comb begin
        rem_w = 32'(rem_q);
        room = 32'((PAGE_BYTES - int'(addr_q[PG_LG-1:0])) >> BB_LG);
        chunk = (room < rem_w && room < 32'(MAX_BEATS)) ? BEATS_W'(room) :
                (rem_w < 32'(MAX_BEATS)) ? BEATS_W'(rem_w) : BEATS_W'(MAX_BEATS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q <= 1'b0;
            addr_q <= '0;
            rem_q <= '0;
            id_q <= '0;
            port_q <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q <= '0;
            cmd_beats_q <= '0;
            cmd_last_q <= 1'b0;
            cmd_port_q <= '0;
            cmd_id_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt_any) begin
                    wr_q <= bus.req_write[gnt_idx];
                    addr_q <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W] & ~ADDR_W'(BEAT_BYTES - 1);
                    rem_q <= RW'(bus.req_len[gnt_idx*LEN_W +: LEN_W]) + RW'(1);
                    id_q <= bus.req_id[gnt_idx*ID_W +: ID_W];
                    port_q <= gnt_idx;
                    state_q <= CALC;
                end
                CALC: begin
                    cmd_write_q <= wr_q;
                    cmd_addr_q <= addr_q;
                    cmd_beats_q <= chunk;
                    cmd_last_q <= 32'(chunk) == rem_w;
                    cmd_port_q <= port_q;
                    cmd_id_q <= id_q;
                    cmd_valid_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: if (bus.cmd_ready) begin
                    cmd_valid_q <= 1'b0;
                    addr_q <= addr_q + (ADDR_W'(cmd_beats_q) << BB_LG);
                    rem_q <= rem_q - RW'(cmd_beats_q);
                    state_q <= WAIT;
                end
                WAIT: if (bus.done) state_q <= (rem_q != '0) ? CALC : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = gnt;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_write = cmd_write_q;
    assign bus.cmd_addr = cmd_addr_q;
    assign bus.cmd_beats = cmd_beats_q;
    assign bus.cmd_last = cmd_last_q;
    assign bus.cmd_port = cmd_port_q;
    assign bus.cmd_id = cmd_id_q;
    assign bus.busy = state_q != IDLE;
endmodule
